// File: rtl/wb4_arb_if.sv
// wb4_arb_if: master-facing and slave-facing Wishbone B4 signals of the round-robin arbiter
interface wb4_arb_if #(
  parameter int ARCHBITSZ   = 32,
  parameter int MASTERCOUNT = 2
);
  localparam int SELBITSZ = ARCHBITSZ / 8;
  logic [MASTERCOUNT-1:0]           m_cyc_i, m_stb_i, m_we_i, m_stall_o, m_ack_o;
  logic [MASTERCOUNT*ARCHBITSZ-1:0] m_addr_i, m_data_i;
  logic [MASTERCOUNT*SELBITSZ-1:0]  m_sel_i;
  logic [ARCHBITSZ-1:0]             m_data_o, s_addr_o, s_data_o, s_data_i;
  logic [SELBITSZ-1:0]              s_sel_o;
  logic                             s_cyc_o, s_stb_o, s_we_o, s_stall_i, s_ack_i;
  modport arb (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i, s_stall_i, s_ack_i, s_data_i,
    output m_stall_o, m_ack_o, m_data_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o
  );
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
    input  m_stall_o, m_ack_o, m_data_o
  );
  modport slave (
    input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o,
    output s_stall_i, s_ack_i, s_data_i
  );
endinterface

// File: rtl/wb4_arb.sv
// wb4_arb: round-robin, CYC-locked arbiter sharing one pipelined Wishbone B4 slave among masters
module wb4_arb #(
  parameter int ARCHBITSZ   = 32,
  parameter int MASTERCOUNT = 2
) (
  input logic wb4_clk_i,
  input logic wb4_rst_i,
  wb4_arb_if.arb bus
);
  localparam int GNTBITSZ = MASTERCOUNT > 1 ? $clog2(MASTERCOUNT) : 1;
  localparam int SELBITSZ = ARCHBITSZ / 8;
  logic                gntvld_q, gntvld_d, own;
  logic [GNTBITSZ-1:0] gnt_q, gnt_d, last_q, last_d, cand;
  // Owner keeps the bus while its CYC is high; otherwise search from last+1 onward.
  always_comb begin
    gntvld_d = gntvld_q && bus.m_cyc_i[gnt_q];
    gnt_d = gnt_q;
    last_d = last_q;
    cand = '0;
    if (!gntvld_d)
      for (int i = MASTERCOUNT; i > 0; i--) begin
        cand = GNTBITSZ'((int'(last_q) + i) % MASTERCOUNT);
        if (bus.m_cyc_i[cand]) begin
          gntvld_d = 1'b1;
          gnt_d = cand;
          last_d = cand;
        end
      end
  end
  always_ff @(posedge wb4_clk_i)
    if (wb4_rst_i) begin
      gntvld_q <= 1'b0;
      gnt_q <= '0;
      last_q <= GNTBITSZ'(MASTERCOUNT - 1);
    end else begin
      gntvld_q <= gntvld_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
    end
  assign own = gntvld_q && !wb4_rst_i;
  assign bus.m_data_o = bus.s_data_i;
  always_comb begin
    bus.s_cyc_o = own && bus.m_cyc_i[gnt_q];
    bus.s_stb_o = own && bus.m_cyc_i[gnt_q] && bus.m_stb_i[gnt_q];
    bus.s_we_o = own && bus.m_we_i[gnt_q];
    bus.s_addr_o = own ? bus.m_addr_i[gnt_q*ARCHBITSZ +: ARCHBITSZ] : '0;
    bus.s_data_o = own ? bus.m_data_i[gnt_q*ARCHBITSZ +: ARCHBITSZ] : '0;
    bus.s_sel_o = own ? bus.m_sel_i[gnt_q*SELBITSZ +: SELBITSZ] : '0;
    bus.m_stall_o = '1;
    bus.m_ack_o = '0;
    if (own) begin
      bus.m_stall_o[gnt_q] = bus.s_stall_i;
      bus.m_ack_o[gnt_q] = bus.s_ack_i && bus.m_cyc_i[gnt_q];
    end
  end
endmodule

// File: tb/tb_wb4_arb.sv
// tb_wb4_arb: randomized scoreboard bench for wb4_arb with three masters against a cycle-level arbitration model
module tb_wb4_arb;
  localparam int N = 3;
  localparam int W = 32;
  typedef struct {
    logic [W-1:0] addr;
    logic [W-1:0] data;
    logic [3:0]   sel;
    logic         we;
  } xfer_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] stq[$];
  logic       idq[$];
  xfer_t      xq[$];
  logic [W-1:0] aq[$];
  wb4_arb_if #(.ARCHBITSZ(W), .MASTERCOUNT(N)) bus ();
  wb4_arb #(.ARCHBITSZ(W), .MASTERCOUNT(N)) dut (.wb4_clk_i(clk), .wb4_rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic underflow(input string nm);
    checks++;
    failures++;
    $display("FAIL %s got=unexpected-output exp=none", nm);
  endtask
  // Monitor: every cycle presents control outputs; transfers and acks are popped when presented.
  always @(negedge clk) if (run) begin
    logic [7:0] e;
    logic idl;
    xfer_t x;
    logic [W-1:0] a;
    if (stq.size() == 0) underflow("ctl");
    else begin
      e = stq.pop_front();
      idl = idq.pop_front();
      chk("ctl", {bus.s_cyc_o, bus.s_stb_o, bus.m_stall_o, bus.m_ack_o}, e);
      if (idl) chk("idle_zero", {bus.s_we_o, bus.s_addr_o, bus.s_data_o, bus.s_sel_o}, 0);
    end
    if (bus.s_cyc_o && bus.s_stb_o && !bus.s_stall_i) begin
      if (xq.size() == 0) underflow("xfer");
      else begin
        x = xq.pop_front();
        chk("xfer", {bus.s_we_o, bus.s_sel_o, bus.s_addr_o, bus.s_data_o}, {x.we, x.sel, x.addr, x.data});
      end
    end
    if (|bus.m_ack_o) begin
      if (aq.size() == 0) underflow("ack");
      else begin
        a = aq.pop_front();
        chk("ack_data", bus.m_data_o, a);
      end
    end
  end
  initial begin
    int ev, eg, el;
    int req[$];
    logic [N-1:0] mc, stall, ack;
    logic [3:0] sel_i;
    logic [W-1:0] ad, dt;
    ev = 0; eg = 0; el = N - 1;
    mc = '0;
    bus.m_cyc_i = '1; bus.m_stb_i = '1; bus.m_we_i = '0;
    bus.m_addr_i = '0; bus.m_data_i = '0; bus.m_sel_i = '0;
    bus.s_stall_i = 1'b0; bus.s_ack_i = 1'b1; bus.s_data_i = '0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      if (n < 3) rst = 1'b1;
      else rst = ($urandom_range(63) == 0);
      for (int i = 0; i < N; i++) begin
        if (n < 4) mc[i] = 1'b1;
        else if (mc[i]) mc[i] = ($urandom_range(3) != 0);
        else mc[i] = ($urandom_range(1) == 0);
        bus.m_stb_i[i] = ($urandom_range(3) != 0);
        bus.m_we_i[i] = $urandom_range(1);
        bus.m_addr_i[i*W +: W] = $urandom;
        bus.m_data_i[i*W +: W] = $urandom;
        bus.m_sel_i[i*4 +: 4] = 4'($urandom);
      end
      bus.m_cyc_i = mc;
      bus.s_stall_i = ($urandom_range(2) == 0);
      bus.s_ack_i = (n < 3) ? 1'b1 : ($urandom_range(2) == 0);
      bus.s_data_i = $urandom;
      stall = '1;
      ack = '0;
      if (ev != 0 && !rst) begin
        stall[eg] = bus.s_stall_i;
        ack[eg] = bus.s_ack_i && mc[eg];
        stq.push_back({mc[eg], mc[eg] && bus.m_stb_i[eg], stall, ack});
        idq.push_back(1'b0);
        if (mc[eg] && bus.m_stb_i[eg] && !bus.s_stall_i) begin
          ad = bus.m_addr_i[eg*W +: W];
          dt = bus.m_data_i[eg*W +: W];
          sel_i = bus.m_sel_i[eg*4 +: 4];
          xq.push_back('{ad, dt, sel_i, bus.m_we_i[eg]});
        end
        if (ack[eg]) aq.push_back(bus.s_data_i);
      end else begin
        stq.push_back({2'b00, stall, ack});
        idq.push_back(1'b1);
      end
      run = 1'b1;
      // Model of the next edge: reset, lock while owner holds CYC, else first requester after last.
      if (rst) begin
        ev = 0; eg = 0; el = N - 1;
      end else if (!(ev != 0 && mc[eg])) begin
        req = {};
        for (int k = 1; k <= N; k++) if (mc[(el + k) % N]) req.push_back((el + k) % N);
        ev = (req.size() > 0) ? 1 : 0;
        if (ev != 0) begin
          eg = req[0];
          el = req[0];
        end
      end
    end
    @(negedge clk);
    #1 run = 1'b0;
    chk("ctl_drain", 32'(stq.size()), 0);
    chk("xfer_drain", 32'(xq.size()), 0);
    chk("ack_drain", 32'(aq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
